// File: rtl/tdm_demux_16_if.sv
//------------------------------------------------------------------------------
// tdm_demux_16_if : serial-in / frame-out bundle for the 1:16 TDM demux.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface tdm_demux_16_if;
    logic        din;
    logic        din_valid;
    logic        sync;
    logic [15:0] dout;
    logic        frame_valid;
    logic        locked;
    logic [3:0]  slot;
    logic        sync_err;

    modport master (
        output din, din_valid, sync,
        input  dout, frame_valid, locked, slot, sync_err
    );

    modport slave (
        input  din, din_valid, sync,
        output dout, frame_valid, locked, slot, sync_err
    );
endinterface

`default_nettype wire

// File: rtl/tdm_demux_16.sv
//------------------------------------------------------------------------------
// tdm_demux_16 : 1:16 time-division demultiplexer / frame deserializer with
//                slot-0 sync marker alignment and registered frame output.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tdm_demux_16 #(
    parameter bit STRICT_SYNC = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    tdm_demux_16_if.slave  bus
);

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam logic [3:0] c_last_slot = 4'd15;

    state_t      r_state;
    logic [3:0]  r_slot;
    logic [15:0] r_shadow;
    logic [15:0] r_dout;
    logic        r_frame_valid;
    logic        r_sync_err;

    state_t      w_state_n;
    logic [3:0]  w_slot_n;
    logic [15:0] w_shadow_n;
    logic [15:0] w_dout_n;
    logic        w_frame_valid_n;
    logic        w_sync_err_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= HUNT;
            r_slot        <= 4'd0;
            r_shadow      <= 16'd0;
            r_dout        <= 16'd0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_slot        <= w_slot_n;
            r_shadow      <= w_shadow_n;
            r_dout        <= w_dout_n;
            r_frame_valid <= w_frame_valid_n;
            r_sync_err    <= w_sync_err_n;
        end
    end

    always_comb begin
        w_state_n       = r_state;
        w_slot_n        = r_slot;
        w_shadow_n      = r_shadow;
        w_dout_n        = r_dout;
        w_frame_valid_n = 1'b0;
        w_sync_err_n    = 1'b0;

        if (bus.din_valid) begin
            unique case (r_state)
                HUNT: begin
                    if (bus.sync) begin
                        w_shadow_n[0] = bus.din;
                        w_slot_n      = 4'd1;
                        w_state_n     = LOCK;
                    end
                end

                LOCK: begin
                    if (bus.sync && (r_slot != 4'd0)) begin
                        // Early sync: restart the frame on this sample.
                        w_sync_err_n  = 1'b1;
                        w_shadow_n[0] = bus.din;
                        w_slot_n      = 4'd1;
                    end else if (!bus.sync && (r_slot == 4'd0) && STRICT_SYNC) begin
                        w_sync_err_n  = 1'b1;
                        w_slot_n      = 4'd0;
                        w_state_n     = HUNT;
                    end else begin
                        w_shadow_n[r_slot] = bus.din;
                        if (r_slot == c_last_slot) begin
                            w_dout_n        = {bus.din, r_shadow[14:0]};
                            w_frame_valid_n = 1'b1;
                            w_slot_n        = 4'd0;
                        end else begin
                            w_slot_n = r_slot + 4'd1;
                        end
                    end
                end

                default: begin
                    w_state_n = HUNT;
                    w_slot_n  = 4'd0;
                end
            endcase
        end
    end

    assign bus.dout        = r_dout;
    assign bus.frame_valid = r_frame_valid;
    assign bus.locked      = (r_state == LOCK);
    assign bus.slot        = r_slot;
    assign bus.sync_err    = r_sync_err;

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux_16.sv
//------------------------------------------------------------------------------
// tb_tdm_demux_16 : self-checking bench for tdm_demux_16 (strict and free-run).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_tdm_demux_16;

    logic clk = 1'b0;
    logic rst;
    logic din;
    logic din_valid;
    logic sync;

    always #5 clk = ~clk;

    tdm_demux_16_if bus_s ();
    tdm_demux_16_if bus_f ();

    assign bus_s.din       = din;
    assign bus_s.din_valid = din_valid;
    assign bus_s.sync      = sync;
    assign bus_f.din       = din;
    assign bus_f.din_valid = din_valid;
    assign bus_f.sync      = sync;

    tdm_demux_16 #(.STRICT_SYNC(1'b1)) dut_strict (.clk(clk), .rst(rst), .bus(bus_s));
    tdm_demux_16 #(.STRICT_SYNC(1'b0)) dut_free   (.clk(clk), .rst(rst), .bus(bus_f));

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int err_cnt = 0;
    logic [15:0] sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard for the strict instance: every strobe must match a pushed frame.
    always @(negedge clk) begin
        if (bus_s.frame_valid) begin
            if (sb.size() == 0) check("unexpected_frame", {16'h0, bus_s.dout}, 32'hFFFF_FFFF);
            else check("sb_frame", {16'h0, bus_s.dout}, {16'h0, sb.pop_front()});
        end
        if (bus_s.sync_err) err_cnt++;
        if (bus_s.frame_valid || bus_s.sync_err)
            check("fv_err_excl", {31'h0, bus_s.frame_valid & bus_s.sync_err}, 32'h0);
    end

    task automatic step(input logic r, input logic d, input logic v, input logic s);
        rst = r; din = d; din_valid = v; sync = s;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [15:0] val, input bit gap, input bit push, input bit exp_err);
        for (int k = 0; k < 16; k++) begin
            if (k == 15 && push) sb.push_back(val);
            step(1'b0, val[k], 1'b1, k == 0);
            if (k == 0) begin
                check("first_err", {31'h0, bus_s.sync_err}, {31'h0, exp_err});
                check("first_slot", {28'h0, bus_s.slot}, 32'd1);
            end
            if (gap && k != 15) begin
                step(1'b0, 1'($urandom_range(1)), 1'b0, 1'($urandom_range(1)));
                check("gap_slot", {28'h0, bus_s.slot}, k + 1);
            end
        end
    endtask

    typedef struct {
        logic       r, d, v, s;
        logic [3:0] slot;
        logic       lk, fv, er;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, c1;
        int e0;
        logic [15:0] f;

        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; din = 1'b0; din_valid = 1'b0; sync = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 2; i++)
            step(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
        check("rst_dout",   {16'h0, bus_s.dout}, 32'h0);
        check("rst_slot",   {28'h0, bus_s.slot}, 32'h0);
        check("rst_locked", {31'h0, bus_s.locked}, 32'h0);
        check("rst_strobe", {30'h0, bus_s.frame_valid, bus_s.sync_err}, 32'h0);

        // Per-cycle control vectors
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].r, tbl[i].d, tbl[i].v, tbl[i].s);
            check($sformatf("vec%0d_strict", i),
                  {25'h0, bus_s.slot, bus_s.locked, bus_s.frame_valid, bus_s.sync_err},
                  {25'h0, tbl[i].slot, tbl[i].lk, tbl[i].fv, tbl[i].er});
            check($sformatf("vec%0d_free", i),
                  {25'h0, bus_f.slot, bus_f.locked, bus_f.frame_valid, bus_f.sync_err},
                  {25'h0, tbl[i].slot, tbl[i].lk, tbl[i].fv, tbl[i].er});
        end
        check("vec_dout", {16'h0, bus_s.dout}, 32'h0);

        // Basic frame
        send_frame(16'hA5C3, 1'b0, 1'b1, 1'b0);
        check("basic_fv",     {31'h0, bus_s.frame_valid}, 32'h1);
        check("basic_dout",   {16'h0, bus_s.dout}, 32'hA5C3);
        check("basic_slot",   {28'h0, bus_s.slot}, 32'h0);
        check("basic_locked", {31'h0, bus_s.locked}, 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("basic_fv_pulse", {31'h0, bus_s.frame_valid}, 32'h0);
        check("basic_dout_hold", {16'h0, bus_s.dout}, 32'hA5C3);

        // Stalls every other cycle
        c0 = cyc;
        send_frame(16'hA5C3, 1'b1, 1'b1, 1'b0);
        check("stall_cycles", cyc - c0, 32'd31);
        check("stall_fv", {31'h0, bus_s.frame_valid}, 32'h1);
        check("stall_dout", {16'h0, bus_s.dout}, 32'hA5C3);

        // Back-to-back frames
        e0 = err_cnt;
        send_frame(16'h1234, 1'b0, 1'b1, 1'b0);
        c0 = cyc;
        check("b2b_dout0", {16'h0, bus_s.dout}, 32'h1234);
        send_frame(16'hFFFF, 1'b0, 1'b1, 1'b0);
        c1 = cyc;
        check("b2b_fv1", {31'h0, bus_s.frame_valid}, 32'h1);
        check("b2b_spacing", c1 - c0, 32'd16);
        check("b2b_dout1", {16'h0, bus_s.dout}, 32'hFFFF);
        check("b2b_no_err", err_cnt - e0, 32'd0);

        // Early sync at slot 7
        e0 = err_cnt;
        f = 16'h0055;
        for (int k = 0; k < 7; k++) step(1'b0, f[k], 1'b1, k == 0);
        check("early_slot7", {28'h0, bus_s.slot}, 32'd7);
        send_frame(16'h0F0F, 1'b0, 1'b1, 1'b1);
        check("early_dout", {16'h0, bus_s.dout}, 32'h0F0F);
        check("early_err_once", err_cnt - e0, 32'd1);
        check("early_free_dout", {16'h0, bus_f.dout}, 32'h0F0F);

        // Missing sync at the second frame's slot 0
        send_frame(16'h5A5A, 1'b0, 1'b1, 1'b0);
        f = 16'h8001;
        step(1'b0, f[0], 1'b1, 1'b0);
        check("miss_s_err",    {31'h0, bus_s.sync_err}, 32'h1);
        check("miss_s_locked", {31'h0, bus_s.locked}, 32'h0);
        check("miss_f_err",    {31'h0, bus_f.sync_err}, 32'h0);
        check("miss_f_slot",   {28'h0, bus_f.slot}, 32'd1);
        for (int k = 1; k < 16; k++) step(1'b0, f[k], 1'b1, 1'b0);
        check("miss_s_slot",   {28'h0, bus_s.slot}, 32'h0);
        check("miss_s_hunt",   {31'h0, bus_s.locked}, 32'h0);
        check("miss_s_dout",   {16'h0, bus_s.dout}, 32'h5A5A);
        check("miss_f_fv",     {31'h0, bus_f.frame_valid}, 32'h1);
        check("miss_f_dout",   {16'h0, bus_f.dout}, 32'h8001);
        send_frame(16'h3C3C, 1'b0, 1'b1, 1'b0);
        check("relock_dout",   {16'h0, bus_s.dout}, 32'h3C3C);
        check("relock_locked", {31'h0, bus_s.locked}, 32'h1);

        // Reset at slot 9
        f = 16'hFFFF;
        for (int k = 0; k < 9; k++) step(1'b0, f[k], 1'b1, k == 0);
        check("mid_slot9", {28'h0, bus_s.slot}, 32'd9);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("mid_rst_dout",   {16'h0, bus_s.dout}, 32'h0);
        check("mid_rst_locked", {31'h0, bus_s.locked}, 32'h0);
        check("mid_rst_slot",   {28'h0, bus_s.slot}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
